// File: rtl/graph_param_ctrl.sv
// rtl/graph_param_ctrl.sv - frame-synchronous round-robin parameter controller (optional GRAPH_PARAM_CTRL_REPEAT_EN)
module graph_param_ctrl #(
    parameter int WIDTH  = 12,
    parameter int STEP   = 50,
    parameter int A_INIT = 250,
    parameter int B_INIT = 0,
    parameter int P_MIN  = 0,
    parameter int P_MAX  = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic [3:0]       req,
    output logic [WIDTH-1:0] param_a,
    output logic [WIDTH-1:0] param_b,
    output logic [3:0]       pending,
    output logic [3:0]       grant,
    output logic             update,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ARB, APPLY} state_t;

    localparam logic [WIDTH:0] STEP_X = STEP[WIDTH:0];
    localparam logic [WIDTH:0] MIN_X  = P_MIN[WIDTH:0];
    localparam logic [WIDTH:0] MAX_X  = P_MAX[WIDTH:0];

    state_t     state, state_nxt;
    logic       vsync_d;
    logic       fs;
    logic [1:0] rr_ptr;
    logic [1:0] idx;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       apply_now;

    assign fs        = vsync_d & ~vsync;
    assign apply_now = (state == APPLY);

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] p);
        logic [WIDTH:0] sum;
        sum = {1'b0, p} + STEP_X;
        return (sum > MAX_X) ? MAX_X[WIDTH-1:0] : sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] p);
        return ({1'b0, p} < (MIN_X + STEP_X)) ? MIN_X[WIDTH-1:0] : (p - STEP_X[WIDTH-1:0]);
    endfunction

    // Round-robin search starting just after the last served requester
    always_comb begin
        pick  = rr_ptr + 2'd1;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && pending[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

`ifdef GRAPH_PARAM_CTRL_REPEAT_EN
    logic [1:0] cnt [4];

    // Per-requester saturating press counters; a press during its own service cancels the decrement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !(apply_now && idx == 2'(i))) begin
                    if (cnt[i] != 2'd3) cnt[i] <= cnt[i] + 2'd1;
                end else if (!req[i] && apply_now && idx == 2'(i) && cnt[i] != 2'd0) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

    // Pending means at least one queued press
    always_comb begin
        for (int i = 0; i < 4; i++) pending[i] = (cnt[i] != 2'd0);
    end
`else
    logic [3:0] pend_q;
    logic [3:0] pend_clr;

    assign pend_clr = apply_now ? (4'b0001 << idx) : 4'b0000;
    assign pending  = pend_q;

    // Single pending flag per requester; a new press wins over the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_q <= 4'b0000;
        else        pend_q <= (pend_q & ~pend_clr) | req;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: one arbitration per frame start, frame starts while busy are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fs && (|pending)) state_nxt = ARB;
            ARB:     state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: vsync history, winner latch, parameter update and strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_d <= 1'b1;
            rr_ptr  <= 2'd3;
            idx     <= 2'd0;
            param_a <= A_INIT[WIDTH-1:0];
            param_b <= B_INIT[WIDTH-1:0];
            grant   <= 4'b0000;
            update  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            grant   <= 4'b0000;
            update  <= 1'b0;
            if (state == ARB) idx <= pick;
            if (apply_now) begin
                case (idx)
                    2'd0: param_a <= step_up(param_a);
                    2'd1: param_a <= step_down(param_a);
                    2'd2: param_b <= step_up(param_b);
                    default: param_b <= step_down(param_b);
                endcase
                grant  <= 4'b0001 << idx;
                update <= 1'b1;
                rr_ptr <= idx;
            end
        end
    end

endmodule

// File: doc/graph_param_ctrl.md
Name: graph_param_ctrl

Overview:
Frame-synchronous parameter controller for the graph display pixel datapath. Collects one-cycle request pulses from up to four debounced push-buttons and arbitrates them round-robin. Applies at most one saturating increment/decrement per frame to two plot parameters (param_a: threshold/coefficient, param_b: offset). Updates happen only at the start of vertical blanking, so the pixel datapath never sees a parameter change mid-frame.

Parameters:
WIDTH, 12, bit width of param_a/param_b (matches hpos/vpos width)
STEP, 50, amount added/subtracted per granted request
A_INIT, 250, reset value of param_a
B_INIT, 0, reset value of param_b
P_MIN, 0, lower saturation bound for both parameters
P_MAX, 799, upper saturation bound for both parameters

Ports:
clk  input  1  pixel clock (clk25 domain); all logic on rising edge
reset  input  1  asynchronous, active-low reset
vsync  input  1  vertical sync from hvsync, active-low, same clock domain
req  input  4  one-cycle request pulses: [0] A up, [1] A down, [2] B up, [3] B down
param_a  output  WIDTH  current parameter A, to pixel datapath
param_b  output  WIDTH  current parameter B, to pixel datapath
pending  output  4  per-requester pending flags
grant  output  4  one-hot, one-cycle pulse marking the request just applied
update  output  1  one-cycle strobe, high in the cycle params change
busy  output  1  high while FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): param_a=A_INIT, param_b=B_INIT, pending=0, grant=0, update=0, busy=0, FSM=IDLE, vsync_d=1, rr_ptr=3 (first search starts at index 0). Any in-flight update is discarded.
- Pending capture: req[i]=1 sets pending[i]. Extra pulses while pending[i]=1 merge into it (see optional feature). Set has priority over clear in the same cycle.
- Frame start: fs = vsync_d & ~vsync, with vsync_d registered every cycle.
- FSM, states IDLE, ARB, APPLY:
  - IDLE: if fs and |pending, go to ARB at that edge (E0); otherwise stay.
  - ARB (E1): pick the first set pending bit searching rr_ptr+1, rr_ptr+2, ... mod 4. Latch it as idx; go to APPLY. Pending is re-evaluated here, so bits set after E0 are eligible.
  - APPLY (E2): update the selected parameter, clear pending[idx], set grant[idx]=1, set update=1, set rr_ptr=idx, return to IDLE.
- Latency: params change at E2, two cycles after vsync is first sampled low. Exactly one update per frame maximum.
- Arithmetic (unsigned, WIDTH bits, computed in WIDTH+1 bits):
  - up: new = min(p+STEP, P_MAX).
  - down: new = (p < P_MIN+STEP) ? P_MIN : p-STEP.
  - No wrap-around in either direction.
- Saturated request: still granted, cleared and strobed even when the value does not change.
- Up and down pending for the same parameter: served in separate frames in round-robin order; no cancellation.
- fs while busy: ignored.
- Multiple pending at fs: only one is served; the rest wait for later frames.
- busy=1 in ARB and APPLY.

Optional Feature:
GRAPH_PARAM_CTRL_REPEAT_EN:
- Defined: each requester has a 2-bit saturating counter instead of a flag (max 3 queued presses). APPLY decrements the counter instead of clearing it. A req pulse in the APPLY cycle for idx leaves the count unchanged (+1-1). pending[i] = (count[i]!=0).
- Undefined: 1-bit flags; repeated presses before service merge into one.

Test Plan:
- Release reset, no req, 3 frames -> param_a=250, param_b=0, update never pulses, grant=0.
- req[0] pulse mid-frame -> pending=0001; at next vsync fall E0, param_a=300 at E2, grant=0001 and update high for one cycle, pending=0000.
- req=1111 in one cycle -> over the next 4 frames grants 0001, 0010, 0100, 1000 in order. Final param_a=250, param_b=0 (B down saturates at 0 after B up to 50).
- Press req[0] 12 times, one per frame, starting at 250 -> saturates at 799 after the 11th; the 12th still grants with update=1 and param_a stays 799.
- req[1] pulse, then reset low at E1 -> immediately param_a=250, pending=0, busy=0; no grant after reset release.
- With GRAPH_PARAM_CTRL_REPEAT_EN: 5 req[2] pulses within one frame -> param_b goes 50, 100, 150 over 3 frames, then stops. Without the macro: only 50.
